// File: rtl/squeeze_bank_writer_pkg.sv
// Shared accelerator package: writer FSM state encoding, default geometry constants
// and a helper for sizing the lane index.
package squeeze_bank_writer_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LANES  = 8;
    localparam int DEF_MAP_H  = 111;
    localparam int DEF_MAP_W  = 111;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } wr_state_e;

    // A single-lane configuration still needs a 1-bit index register.
    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/squeeze_bank_writer_if.sv
// Feature-stream input handshake plus the bank write port of the squeeze bank writer.
// slave = the writer itself, master = the stream source / bank model.
interface squeeze_bank_writer_if
    import squeeze_bank_writer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic                      in_valid;
    logic [DATA_W-1:0]         in_data;
    logic                      in_ready;
    logic                      wren;
    logic [ADDR_W-1:0]         address1;
    logic [DATA_W*LANES-1:0]   datain;

    modport master (
        output in_valid, in_data,
        input  in_ready, wren, address1, datain
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wren, address1, datain
    );
endinterface

// File: rtl/squeeze_bank_writer_lane_packer.sv
// Packs consecutive channel values into LANES registers; optional ReLU via WRITER_RELU_EN.
// Latency: value visible in its lane the cycle after acceptance. No backpressure of its own.
// Lanes keep old contents until overwritten; only the index is cleared at pass start.
module lane_packer
    import squeeze_bank_writer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    accept,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W*LANES-1:0] lanes,
    output logic                    last
);
    localparam int IDX_W = idx_width(LANES);

    logic [IDX_W-1:0]              idx;
    logic [LANES-1:0][DATA_W-1:0]  lane_q;
    logic [DATA_W-1:0]             din_v;

`ifdef WRITER_RELU_EN
    assign din_v = din[DATA_W-1] ? '0 : din;
`else
    assign din_v = din;
`endif

    assign last  = (idx == IDX_W'(LANES - 1));
    assign lanes = lane_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx    <= '0;
            lane_q <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (accept) begin
            lane_q[idx] <= din_v;
            idx         <= last ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/squeeze_bank_writer.sv
// Collects LANES channel values per pixel and writes them as one packed bank word per pixel.
// Latency: wren one cycle after the last lane is accepted; done one cycle after the final write.
// Backpressure: in_ready only in COLLECT; in_valid gaps stall without loss. Option: WRITER_RELU_EN.
module squeeze_bank_writer
    import squeeze_bank_writer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int MAP_H  = DEF_MAP_H,
    parameter int MAP_W  = DEF_MAP_W,
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    squeeze_bank_writer_if.slave  bus,
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_H * MAP_W - 1);

    wr_state_e          state;
    logic [ADDR_W-1:0]  addr_q;
    logic               wren_q;
    logic               busy_q;
    logic               done_q;
    logic               accept;
    logic               last_lane;
    logic               start_take;

    assign accept     = (state == COLLECT) && bus.in_valid;
    assign start_take = (state == IDLE) && start;

    lane_packer #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_pack (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_take),
        .accept (accept),
        .din    (bus.in_data),
        .lanes  (bus.datain),
        .last   (last_lane)
    );

    assign bus.in_ready = (state == COLLECT);
    assign bus.wren     = wren_q;
    assign bus.address1 = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            addr_q <= '0;
            wren_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= COLLECT;
                        addr_q <= '0;
                        busy_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept && last_lane) begin
                        state  <= WRITE;
                        wren_q <= 1'b1;
                    end
                end
                WRITE: begin
                    // The final pixel keeps its address through DONE; it is cleared on the way to IDLE.
                    if (addr_q == LAST_ADDR) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                        state  <= COLLECT;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    addr_q <= '0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
